// File: rtl/pipeline_core_hz.sv
// pipeline_core_hz: 5-stage MIPS datapath with built-in hazard detection, forwarding, regfile and ALU
module pipeline_core_hz #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [XLEN-1:0]  pcf,
    input  logic [31:0]      instrf,
    output logic [31:0]      instrd,
    input  logic [9:0]       ctrld,
    output logic [XLEN-1:0]  aluoutm,
    output logic [XLEN-1:0]  writedatam,
    output logic             memwritem,
    output logic             memreadm,
    input  logic [XLEN-1:0]  readdatam,
    input  logic             dmem_ready,
    output logic [CNT_W-1:0] stall_count
);
    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] pcplus4f, pcplus4d, pcnext, signimmd, pcbranchd, pcjumpd;
    logic [XLEN-1:0] rd1d, rd2d, cmpa, cmpb;
    logic [4:0]      rsd, rtd, rdd;
    logic            branchd, jumpd, eqd, pcsrcd;
    logic            regwritee, memtorege, memwritee, alusrce, regdste;
    logic [2:0]      alucontrole;
    logic [XLEN-1:0] rd1e, rd2e, signimme, srcae, srcbe, writedatae, aluoute;
    logic [4:0]      rse, rte, rde, writerege;
    logic            regwritem, memtoregm;
    logic [4:0]      writeregm;
    logic            regwritew, memtoregw;
    logic [XLEN-1:0] readdataw, aluoutw, resultw;
    logic [4:0]      writeregw;
    logic            lwstall, branchstall, hz, memwait, redirect;

    assign rsd       = instrd[25:21];
    assign rtd       = instrd[20:16];
    assign rdd       = instrd[15:11];
    assign branchd   = ctrld[1];
    assign jumpd     = ctrld[0];
    assign pcplus4f  = pcf + XLEN'(4);
    assign signimmd  = {{(XLEN-16){instrd[15]}}, instrd[15:0]};
    assign pcbranchd = pcplus4d + (signimmd << 2);
    assign pcjumpd   = {pcplus4d[XLEN-1:28], instrd[25:0], 2'b00};
    assign resultw   = memtoregw ? readdataw : aluoutw;
    assign memreadm  = memtoregm;
    assign writerege = regdste ? rde : rte;

    // decode-stage register reads with write-back bypass, branch compare with M forwarding
    always_comb begin
        rd1d = (rsd == 5'd0) ? '0 : (regwritew && rsd == writeregw) ? resultw : rf[rsd];
        rd2d = (rtd == 5'd0) ? '0 : (regwritew && rtd == writeregw) ? resultw : rf[rtd];
        cmpa = (rsd != 5'd0 && regwritem && rsd == writeregm) ? aluoutm : rd1d;
        cmpb = (rtd != 5'd0 && regwritem && rtd == writeregm) ? aluoutm : rd2d;
        eqd = cmpa == cmpb;
        pcsrcd = jumpd | (branchd & eqd);
    end

    // hazard detection and next-PC selection; memory wait dominates everything
    always_comb begin
        lwstall = memtorege && (rte == rsd || rte == rtd);
        branchstall = branchd &&
            ((regwritee && writerege != 5'd0 && (writerege == rsd || writerege == rtd)) ||
             (memtoregm && writeregm != 5'd0 && (writeregm == rsd || writeregm == rtd)));
        hz = lwstall | branchstall;
        memwait = (memreadm | memwritem) & ~dmem_ready;
        redirect = pcsrcd & ~hz & ~memwait;
        pcnext = !redirect ? pcplus4f : jumpd ? pcjumpd : pcbranchd;
    end

    // execute-stage operand forwarding (M before W) and ALU
    always_comb begin
        srcae = (rse != 5'd0 && regwritem && rse == writeregm) ? aluoutm :
                (rse != 5'd0 && regwritew && rse == writeregw) ? resultw : rd1e;
        writedatae = (rte != 5'd0 && regwritem && rte == writeregm) ? aluoutm :
                     (rte != 5'd0 && regwritew && rte == writeregw) ? resultw : rd2e;
        srcbe = alusrce ? signimme : writedatae;
        aluoute = (alucontrole == 3'b010) ? srcae + srcbe :
                  (alucontrole == 3'b110) ? srcae - srcbe :
                  (alucontrole == 3'b000) ? (srcae & srcbe) :
                  (alucontrole == 3'b001) ? (srcae | srcbe) :
                  (alucontrole == 3'b111) ? XLEN'($signed(srcae) < $signed(srcbe)) : '0;
    end

    // PC and F->D register: held on any stall, decode slot flushed on redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf <= RESET_PC;
            instrd <= '0;
            pcplus4d <= '0;
        end else if (enable && !memwait && !hz) begin
            pcf <= pcnext;
            instrd <= redirect ? '0 : instrf;
            pcplus4d <= redirect ? '0 : pcplus4f;
        end
    end

    // D->E register: bubble on hazard; while memory waits the held instruction keeps its
    // operands current, since the W-stage producer it forwards from drains into a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {regwritee, memtorege, memwritee, alucontrole, alusrce, regdste} <= '0;
            {rd1e, rd2e, signimme} <= '0;
            {rse, rte, rde} <= '0;
        end else if (enable) begin
            if (memwait) begin
                rd1e <= srcae;
                rd2e <= writedatae;
            end else if (hz) begin
                {regwritee, memtorege, memwritee, alucontrole, alusrce, regdste} <= '0;
                {rd1e, rd2e, signimme} <= '0;
                {rse, rte, rde} <= '0;
            end else begin
                {regwritee, memtorege, memwritee, alucontrole, alusrce, regdste} <= ctrld[9:2];
                rd1e <= rd1d;
                rd2e <= rd2d;
                signimme <= signimmd;
                rse <= rsd;
                rte <= rtd;
                rde <= rdd;
            end
        end
    end

    // E->M register: frozen while the memory access is outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {regwritem, memtoregm, memwritem} <= '0;
            aluoutm <= '0;
            writedatam <= '0;
            writeregm <= '0;
        end else if (enable && !memwait) begin
            regwritem <= regwritee;
            memtoregm <= memtorege;
            memwritem <= memwritee;
            aluoutm <= aluoute;
            writedatam <= writedatae;
            writeregm <= writerege;
        end
    end

    // M->W register: takes a bubble while the memory access is outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {regwritew, memtoregw} <= '0;
            readdataw <= '0;
            aluoutw <= '0;
            writeregw <= '0;
        end else if (enable) begin
            regwritew <= regwritem & ~memwait;
            memtoregw <= memtoregm;
            readdataw <= readdatam;
            aluoutw <= aluoutm;
            writeregw <= writeregm;
        end
    end

    // register file write port; r0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (enable && regwritew && writeregw != 5'd0) begin
            rf[writeregw] <= resultw;
        end
    end

    // saturating count of cycles lost to hazards or memory waits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_count <= '0;
        else if (enable && (hz || memwait) && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_pipeline_core_hz.sv
// tb_pipeline_core_hz: directed and random programs checked against an instruction-level model
module tb_pipeline_core_hz;
    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset, enable, dmem_ready, memwritem, memreadm;
    logic [31:0] pcf, instrf, instrd, aluoutm, writedatam, readdatam;
    logic [9:0]  ctrld;
    logic [15:0] stall_count;

    logic [31:0] imem [64];
    logic [31:0] dinit [64];
    logic [31:0] dmem [64];
    logic [63:0] written;
    logic [31:0] prog [$];
    logic [63:0] exp_st [$];
    logic [63:0] dut_st [$];
    logic [5:0]  fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [31:0] off;
    bit          rnd = 0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    pipeline_core_hz #(.XLEN(32), .RESET_PC(RPC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pcf(pcf), .instrf(instrf),
        .instrd(instrd), .ctrld(ctrld), .aluoutm(aluoutm), .writedatam(writedatam),
        .memwritem(memwritem), .memreadm(memreadm), .readdatam(readdatam),
        .dmem_ready(dmem_ready), .stall_count(stall_count)
    );

    // external controller decode for the instruction in D
    function automatic logic [9:0] ctrl(logic [31:0] i);
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h20: return {3'b100, 3'b010, 4'b0100};
                6'h22: return {3'b100, 3'b110, 4'b0100};
                6'h24: return {3'b100, 3'b000, 4'b0100};
                6'h25: return {3'b100, 3'b001, 4'b0100};
                6'h2a: return {3'b100, 3'b111, 4'b0100};
                default: return 10'd0;
            endcase
            6'h23: return {3'b110, 3'b010, 4'b1000};
            6'h2b: return {3'b001, 3'b010, 4'b1000};
            6'h04: return {3'b000, 3'b110, 4'b0010};
            6'h08: return {3'b100, 3'b010, 4'b1000};
            6'h02: return 10'b0000000001;
            default: return 10'd0;
        endcase
    endfunction

    always_comb begin
        ctrld = ctrl(instrd);
        off = pcf - RPC;
        instrf = (off[31:8] == 24'd0) ? imem[off[7:2]] : 32'd0;
        readdatam = written[aluoutm[7:2]] ? dmem[aluoutm[7:2]] : dinit[aluoutm[7:2]];
    end

    always @(posedge clk) begin
        if (reset) written <= '0;
        else if (enable && memwritem && dmem_ready) begin
            dmem[aluoutm[7:2]] <= writedatam;
            written[aluoutm[7:2]] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) dut_st.delete();
        else if (enable && memwritem && dmem_ready) dut_st.push_back({aluoutm, writedatam});
    end

    function automatic logic [31:0] r_op(logic [5:0] f, int rd, int rs, int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction
    function automatic logic [31:0] i_op(logic [5:0] op, int rt, int rs, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_op(int idx);
        return {6'h02, 26'((RPC >> 2) + 32'(idx))};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            dmem_ready = $urandom_range(0, 3) != 0;
            enable = $urandom_range(0, 7) != 0;
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1; enable = 1; dmem_ready = 1;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    // sequential instruction-set interpreter producing the expected store trace
    task automatic run_model();
        logic [31:0] r [32];
        logic [31:0] mm [64];
        logic [31:0] ins, a, b, si, ea, v, pc4, tgt;
        logic        ok;
        int          idx, steps;
        exp_st.delete();
        for (int i = 0; i < 32; i++) r[i] = 0;
        for (int i = 0; i < 64; i++) mm[i] = dinit[i];
        idx = 0;
        steps = 0;
        while (idx >= 0 && idx < prog.size() && steps < 500) begin
            ins = prog[idx];
            a = r[ins[25:21]];
            b = r[ins[20:16]];
            si = {{16{ins[15]}}, ins[15:0]};
            ea = a + si;
            steps++;
            idx++;
            case (ins[31:26])
                6'h00: begin
                    ok = 1;
                    v = 0;
                    case (ins[5:0])
                        6'h20: v = a + b;
                        6'h22: v = a - b;
                        6'h24: v = a & b;
                        6'h25: v = a | b;
                        6'h2a: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: ok = 0;
                    endcase
                    if (ok && ins[15:11] != 0) r[ins[15:11]] = v;
                end
                6'h08: if (ins[20:16] != 0) r[ins[20:16]] = ea;
                6'h23: if (ins[20:16] != 0) r[ins[20:16]] = mm[ea[7:2]];
                6'h2b: begin
                    exp_st.push_back({ea, b});
                    mm[ea[7:2]] = b;
                end
                6'h04: if (a == b) idx = idx + int'($signed(si));
                6'h02: begin
                    pc4 = RPC + 32'(idx) * 4;
                    tgt = {pc4[31:28], ins[25:0], 2'b00};
                    idx = int'((tgt - RPC) >> 2);
                end
                default: ;
            endcase
        end
    endtask

    task automatic run_dut(int budget);
        int c = 0;
        while (dut_st.size() < exp_st.size() && c < budget) begin
            tick();
            c++;
        end
        repeat (12) tick();
        check("st_cnt", dut_st.size(), exp_st.size());
        for (int i = 0; i < exp_st.size() && i < dut_st.size(); i++) begin
            check("st_addr", dut_st[i][63:32], exp_st[i][63:32]);
            check("st_data", dut_st[i][31:0], exp_st[i][31:0]);
        end
    endtask

    function automatic logic [31:0] first_data();
        return dut_st.size() > 0 ? dut_st[0][31:0] : 32'hdead_beef;
    endfunction

    initial begin
        int c;
        logic [31:0] p0;
        reset = 1; enable = 1; dmem_ready = 1;
        for (int i = 0; i < 64; i++) dinit[i] = $urandom;
        dinit[0] = 32'd9;

        // forwarding from M, no stall
        prog = {i_op(6'h08, 2, 0, 5), i_op(6'h08, 3, 0, 7), r_op(6'h20, 1, 2, 3),
                r_op(6'h22, 4, 1, 2), i_op(6'h2b, 4, 0, 0)};
        load_prog(); run_model(); do_reset(); run_dut(200);
        check("fwd_r4", first_data(), 32'd7);
        check("fwd_stalls", stall_count, 0);

        // load-use: one bubble
        prog = {i_op(6'h23, 1, 0, 0), r_op(6'h20, 2, 1, 1), i_op(6'h2b, 2, 0, 4)};
        load_prog(); run_model(); do_reset(); run_dut(200);
        check("lw_r2", first_data(), 32'd18);
        check("lw_stalls", stall_count, 1);

        // asynchronous reset in mid-run, then freeze with enable low
        do_reset();
        repeat (4) tick();
        check("pre_rst_stall", stall_count, 1);
        #2 reset = 1;
        #1;
        check("rst_pc", pcf, RPC);
        check("rst_instrd", instrd, 0);
        check("rst_memwrite", memwritem, 0);
        check("rst_stall", stall_count, 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        check("rst_pc1", pcf, RPC + 4);
        enable = 0;
        repeat (3) tick();
        check("en_pc", pcf, RPC + 4);
        check("en_instrd", instrd, prog[0]);
        enable = 1;

        // branch dependent on previous ALU result
        prog = {i_op(6'h08, 5, 0, 1), r_op(6'h20, 1, 0, 0), i_op(6'h04, 0, 1, 2),
                i_op(6'h08, 5, 0, 2), i_op(6'h08, 5, 0, 3), i_op(6'h2b, 5, 0, 0)};
        load_prog(); run_model(); do_reset();
        repeat (3) tick();
        check("br_instrd", instrd, prog[2]);
        tick();
        check("br_hold_pc", pcf, RPC + 32'hC);
        check("br_stall", stall_count, 1);
        tick();
        check("br_target", pcf, RPC + 32'h14);
        check("br_flush", instrd, 0);
        tick();
        check("br_sw", instrd, prog[5]);
        run_dut(200);
        check("br_stalls", stall_count, 1);

        // store held by data-memory wait
        prog = {i_op(6'h08, 2, 0, 32'h55), i_op(6'h2b, 2, 0, 8)};
        load_prog(); run_model(); do_reset();
        c = 0;
        while (!memwritem && c < 20) begin
            tick();
            c++;
        end
        check("sw_seen", memwritem, 1);
        dmem_ready = 0;
        p0 = pcf;
        repeat (3) begin
            tick();
            check("sw_hold_we", memwritem, 1);
            check("sw_hold_addr", aluoutm, 8);
            check("sw_hold_data", writedatam, 32'h55);
            check("sw_hold_pc", pcf, p0);
        end
        dmem_ready = 1;
        tick();
        check("sw_done", memwritem, 0);
        check("sw_stalls", stall_count, 3);
        run_dut(200);

        // writes to r0 are discarded and never forwarded
        prog = {i_op(6'h08, 2, 0, 5), i_op(6'h08, 3, 0, 7), r_op(6'h20, 0, 2, 3),
                r_op(6'h20, 6, 0, 2), i_op(6'h2b, 6, 0, 0), i_op(6'h2b, 0, 0, 4)};
        load_prog(); run_model(); do_reset(); run_dut(200);
        check("r0_dep", first_data(), 32'd5);

        // random programs with random memory wait and enable gaps
        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(20, 40);
            prog.delete();
            for (int i = 0; i < n; i++) begin
                int k, rs, rt, rd, lim;
                k = $urandom_range(0, 9);
                rs = $urandom_range(0, 7);
                rt = $urandom_range(0, 7);
                rd = $urandom_range(0, 7);
                lim = (n - 1 - i) < 3 ? n - 1 - i : 3;
                case (k)
                    0, 1, 2, 3: prog.push_back(r_op(fn[$urandom_range(0, 4)], rd, rs, rt));
                    4: prog.push_back(i_op(6'h08, rt, rs, $urandom_range(0, 65535)));
                    5: prog.push_back(i_op(6'h23, rt, rs, 4 * $urandom_range(0, 63)));
                    6: prog.push_back(i_op(6'h2b, rt, rs, 4 * $urandom_range(0, 63)));
                    7: prog.push_back(i_op(6'h04, rt, rs, $urandom_range(0, lim)));
                    8: prog.push_back(j_op(i + 1 + $urandom_range(0, lim)));
                    default: prog.push_back(32'd0);
                endcase
            end
            for (int r = 1; r < 8; r++) prog.push_back(i_op(6'h2b, r, 0, 32'h80 + 4 * r));
            for (int i = 0; i < 64; i++) dinit[i] = $urandom;
            load_prog(); run_model();
            rnd = 0;
            do_reset();
            rnd = 1;
            run_dut(3000);
            rnd = 0;
            enable = 1;
            dmem_ready = 1;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
